// File: rtl/sm_reg_uart_dump.sv
// Register-file dump over UART: walks registers 0..REG_LAST, sending each as 8 upper-case hex digits + CR LF.
// Each register takes 1 addr + 1 capture + 100*BAUD_DIV send + 1 next cycles; start is ignored while busy.
module sm_reg_uart_dump #(
    parameter int unsigned BAUD_DIV = 868,
    parameter logic [4:0]  REG_LAST = 5'd31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_DIV - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_NEXT    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [4:0]    reg_addr_q, reg_addr_d;
    logic [31:0]   cap_q, cap_d;
    logic [3:0]    byte_q, byte_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] baud_q, baud_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [9:0]    frame;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] frame_byte(input logic [31:0] w, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = hex_ascii(w[31:28]);
            4'd1:    b = hex_ascii(w[27:24]);
            4'd2:    b = hex_ascii(w[23:20]);
            4'd3:    b = hex_ascii(w[19:16]);
            4'd4:    b = hex_ascii(w[15:12]);
            4'd5:    b = hex_ascii(w[11:8]);
            4'd6:    b = hex_ascii(w[7:4]);
            4'd7:    b = hex_ascii(w[3:0]);
            4'd8:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d    = state_q;
        reg_addr_d = reg_addr_q;
        cap_d      = cap_q;
        byte_d     = byte_q;
        bit_d      = bit_q;
        baud_d     = baud_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ADDR;
                    reg_addr_d = 5'd0;
                end
            end
            S_ADDR: state_d = S_CAPTURE;
            S_CAPTURE: begin
                cap_d   = regData;
                byte_d  = 4'd0;
                bit_d   = 4'd0;
                baud_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                // Byte boundaries roll straight into the next start bit: no idle gap in a register frame.
                if (baud_q == BAUD_MAX) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d = 4'd0;
                        if (byte_q == 4'd9) begin
                            byte_d  = 4'd0;
                            state_d = S_NEXT;
                        end else begin
                            byte_d = byte_q + 4'd1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_NEXT: begin
                if (reg_addr_q == REG_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    reg_addr_d = reg_addr_q + 5'd1;
                    state_d    = S_ADDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from next-state values so the registered copies line up with the FSM state.
    always_comb begin
        frame  = {1'b1, frame_byte(cap_d, byte_d), 1'b0};
        tx_d   = (state_d == S_SEND) ? frame[bit_d] : 1'b1;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_NEXT) && (reg_addr_d == REG_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            reg_addr_q <= 5'd0;
            cap_q      <= 32'h0;
            byte_q     <= 4'd0;
            bit_q      <= 4'd0;
            baud_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_addr_q <= reg_addr_d;
            cap_q      <= cap_d;
            byte_q     <= byte_d;
            bit_q      <= bit_d;
            baud_q     <= baud_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign regAddr = reg_addr_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sm_reg_uart_dump.sv
// Directed bench for sm_reg_uart_dump: BAUD_DIV=4 with a two-register instance and a single-register instance.
module tb_sm_reg_uart_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start0;
    logic [4:0]  reg_addr, reg_addr0;
    logic [31:0] r0, r1, reg_data, reg_data0;
    logic        tx, busy, done, tx0, busy0, done0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign reg_data  = (reg_addr == 5'd0) ? r0 : r1;
    assign reg_data0 = (reg_addr0 == 5'd0) ? 32'hFFFF_FFFF : 32'h0;

    sm_reg_uart_dump #(.BAUD_DIV(4), .REG_LAST(5'd1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .regAddr(reg_addr),
        .regData(reg_data), .tx(tx), .busy(busy), .done(done)
    );

    sm_reg_uart_dump #(.BAUD_DIV(4), .REG_LAST(5'd0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .regAddr(reg_addr0),
        .regData(reg_data0), .tx(tx0), .busy(busy0), .done(done0)
    );

    // Waits for a start bit, samples every bit mid-cell; ok=0 on timeout or bad start/stop bit.
    task automatic recv_byte(input bit sel, output logic [7:0] b, output bit ok);
        int n;
        b  = 8'h00;
        ok = 1'b0;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((sel ? tx0 : tx) !== 1'b0) && (n < 3000));
        if ((sel ? tx0 : tx) !== 1'b0) return;
        repeat (2) @(negedge clk);
        if ((sel ? tx0 : tx) !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            b[i] = sel ? tx0 : tx;
        end
        repeat (4) @(negedge clk);
        ok = ((sel ? tx0 : tx) === 1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; start0 = 1'b0; r0 = 32'h0; r1 = 32'h0;
        repeat (3) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (reg_addr !== 5'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", reg_addr); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b0 || tx !== 1'b1) begin
            bad++; $display("FAIL idle_without_start: busy=%b tx=%b want busy=0 tx=1", busy, tx);
        end
    endtask

    task automatic test_dump;
        string      hex = "000000001234ABCD";
        logic [7:0] b, e;
        bit         ok;
        int         a0, n;
        r0 = 32'h0000_0000; r1 = 32'h1234_ABCD;
        start = 1'b1; @(negedge clk); start = 1'b0;
        a0 = cyc;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL dump_busy: got %b want 1", busy); end
        total++; if (reg_addr !== 5'd0) begin bad++; $display("FAIL dump_addr0: got %0d want 0", reg_addr); end
        for (int k = 0; k < 20; k++) begin
            recv_byte(1'b0, b, ok);
            if ((k % 10) < 8) e = hex[(k / 10) * 8 + (k % 10)];
            else if ((k % 10) == 8) e = 8'h0D;
            else e = 8'h0A;
            total++; if (!ok || b !== e) begin
                bad++; $display("FAIL dump_byte%0d: got %h (frame ok=%0d) want %h", k, b, ok, e);
            end
            if (k == 5) begin start = 1'b1; @(negedge clk); start = 1'b0; end
        end
        n = 0;
        while (done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL dump_done: got %b want 1", done); end
        total++; if (cyc - a0 + 1 != 806) begin
            bad++; $display("FAIL dump_length: got %0d want 806", cyc - a0 + 1);
        end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL dump_after: done=%b busy=%b want 0 0", done, busy);
        end
        total++; if (reg_addr !== 5'd1) begin bad++; $display("FAIL dump_addr_hold: got %0d want 1", reg_addr); end
        n = 0;
        repeat (10) begin @(negedge clk); if (busy !== 1'b0) n++; end
        total++; if (n != 0) begin bad++; $display("FAIL dump_no_queue: busy cycles %0d want 0", n); end
    endtask

    task automatic test_bit_timing;
        logic [9:0] frame;
        int         n;
        frame = {1'b1, 8'h31, 1'b0};
        r0 = 32'h1000_0000; r1 = 32'h0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        for (int c = 0; c < 40; c++) begin
            total++; if (tx !== frame[c / 4]) begin
                bad++; $display("FAIL bit_timing_c%0d: got %b want %b", c, tx, frame[c / 4]);
            end
            @(negedge clk);
        end
        n = 0;
        while (done !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL bit_timing_done: got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_capture_hold;
        string      hex = "89ABCDEF";
        logic [7:0] b, e;
        bit         ok;
        int         n;
        r0 = 32'h89AB_CDEF; r1 = 32'h0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            recv_byte(1'b0, b, ok);
            if (k == 0) r0 = 32'h0000_0000;
            if (k < 8) e = hex[k];
            else if (k == 8) e = 8'h0D;
            else e = 8'h0A;
            total++; if (!ok || b !== e) begin
                bad++; $display("FAIL capture_byte%0d: got %h (frame ok=%0d) want %h", k, b, ok, e);
            end
        end
        n = 0;
        while (done !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL capture_done: got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_start_held;
        int n, drops;
        r0 = 32'h0; r1 = 32'h1234_ABCD;
        start = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL held_busy: got %b want 1", busy); end
        n = 0; drops = 0;
        while (done !== 1'b1 && n < 900) begin
            @(negedge clk);
            n++;
            if (busy !== 1'b1) drops++;
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL held_done: got %b want 1", done); end
        total++; if (drops != 0) begin bad++; $display("FAIL held_busy_drop: got %0d want 0", drops); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_idle: busy=%b want 0", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b1 || reg_addr !== 5'd0) begin
            bad++; $display("FAIL held_restart: busy=%b addr=%0d want 1 0", busy, reg_addr);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        bit         ok;
        int         n, dn, bz;
        n = 0;
        while (reg_addr !== 5'd1 && n < 600) begin @(negedge clk); n++; end
        total++; if (reg_addr !== 5'd1) begin bad++; $display("FAIL mid_reach_r1: got %0d want 1", reg_addr); end
        repeat (3) recv_byte(1'b0, b, ok);
        n = 0;
        while (tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL mid_start_bit: got %b want 0", tx); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_tx: got %b want 1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        total++; if (reg_addr !== 5'd0) begin bad++; $display("FAIL mid_addr: got %0d want 0", reg_addr); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_done: got %b want 0", done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0; bz = 0;
        repeat (60) begin
            @(negedge clk);
            if (done !== 1'b0) dn++;
            if (busy !== 1'b0 || tx !== 1'b1) bz++;
        end
        total++; if (dn != 0) begin bad++; $display("FAIL mid_no_done: got %0d pulses want 0", dn); end
        total++; if (bz != 0) begin bad++; $display("FAIL mid_fresh_start: got %0d active cycles want 0", bz); end
    endtask

    task automatic test_single_reg;
        string      hex = "FFFFFFFF";
        logic [7:0] b, e;
        bit         ok;
        int         n, dn;
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy0); end
        for (int k = 0; k < 10; k++) begin
            recv_byte(1'b1, b, ok);
            if (k < 8) e = hex[k];
            else if (k == 8) e = 8'h0D;
            else e = 8'h0A;
            total++; if (!ok || b !== e || reg_addr0 !== 5'd0) begin
                bad++; $display("FAIL single_byte%0d: got %h (ok=%0d addr=%0d) want %h addr 0", k, b, ok, reg_addr0, e);
            end
        end
        n = 0;
        while (done0 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        total++; if (done0 !== 1'b1) begin bad++; $display("FAIL single_done: got %b want 1", done0); end
        dn = 0;
        repeat (30) begin @(negedge clk); if (done0 !== 1'b0) dn++; end
        total++; if (dn != 0 || busy0 !== 1'b0 || reg_addr0 !== 5'd0) begin
            bad++; $display("FAIL single_after: extra_done=%0d busy=%b addr=%0d want 0 0 0", dn, busy0, reg_addr0);
        end
    endtask

    initial begin
        test_reset();
        test_dump();
        test_bit_timing();
        test_capture_hold();
        test_start_held();
        test_reset_mid();
        test_single_reg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
